// File: rtl/demux_serial_driver_if.sv
// Frame handshake and demux-facing outputs of demux_serial_driver.
// The master side feeds frames in; the slave side is the serialiser.
interface demux_serial_driver_if #(
    parameter int unsigned DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_addr;
    logic [DW-1:0] in_data;
    logic [1:0]    s;
    logic          i;
    logic          frame_act;
    logic          done;

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        input  in_ready,
        input  s,
        input  i,
        input  frame_act,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        output in_ready,
        output s,
        output i,
        output frame_act,
        output done
    );
endinterface

// File: rtl/demux_serial_driver.sv
// Frame serialiser feeding the 1-to-4 demux: latches {addr, data} on accept, holds the
// select for the whole frame and shifts the payload out MSB-first, then idles GAP cycles.
module demux_serial_driver #(
    parameter int unsigned DW  = 8,
    parameter int unsigned GAP = 1
) (
    input logic                  clk,
    input logic                  rst,
    demux_serial_driver_if.slave bus
);
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [DW-1:0]   r_shift;
    logic [DW-1:0]   w_shift_next;
    logic [CW-1:0]   r_bit_cnt;
    logic [CW-1:0]   w_bit_cnt_next;
    logic [GW-1:0]   r_gap_cnt;
    logic [GW-1:0]   w_gap_cnt_next;
    logic [1:0]      r_s;
    logic [1:0]      w_s_next;
    logic            r_i;
    logic            w_i_next;
    logic            r_frame_act;
    logic            w_frame_act_next;
    logic            r_done;
    logic            w_done_next;

    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_bit_cnt_next   = r_bit_cnt;
        w_gap_cnt_next   = r_gap_cnt;
        w_s_next         = r_s;
        // Serial bit and strobes default low so the demux sees 0 outside a frame.
        w_i_next         = 1'b0;
        w_frame_act_next = 1'b0;
        w_done_next      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_s_next         = bus.in_addr;
                    w_i_next         = bus.in_data[DW-1];
                    w_frame_act_next = 1'b1;
                    w_shift_next     = bus.in_data << 1;
                    w_bit_cnt_next   = CW'(DW - 1);
                    w_state_next     = StShift;
                end
            end
            StShift: begin
                if (r_bit_cnt == '0) begin
                    w_done_next = 1'b1;
                    if (GAP != 0) begin
                        w_gap_cnt_next = GW'(GAP - 1);
                        w_state_next   = StGap;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else begin
                    w_i_next         = r_shift[DW-1];
                    w_frame_act_next = 1'b1;
                    w_shift_next     = r_shift << 1;
                    w_bit_cnt_next   = r_bit_cnt - CW'(1);
                end
            end
            StGap: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = StIdle;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - GW'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_s         <= 2'b00;
            r_i         <= 1'b0;
            r_frame_act <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_s         <= w_s_next;
            r_i         <= w_i_next;
            r_frame_act <= w_frame_act_next;
            r_done      <= w_done_next;
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.s         = r_s;
    assign bus.i         = r_i;
    assign bus.frame_act = r_frame_act;
    assign bus.done      = r_done;
endmodule
